// File: rtl/fluxo_dados_contador.sv
// fluxo_dados_contador: datapath answering the counter/register control unit.
//   Executes zera/conta/registra commands, reports end-of-count combinationally,
//   captures a data word, counts accepted captures and flags protocol errors.
// Ports:
//   clock_i           rising-edge system clock
//   reset_i           asynchronous active-high reset
//   zera_i            clear counter (also disarms capture and clears pronto)
//   conta_i           count enable
//   registra_i        capture request
//   dados_i           word to capture
//   fim_contador_o    high while contagem == MODULO-1 (combinational)
//   contagem_o        current counter value
//   dado_registrado_o last accepted word
//   num_registros_o   accepted captures, saturating at 255
//   pronto_o          a capture has been accepted since the last zera
//   erro_o            sticky: a registra arrived without a completed count
module fluxo_dados_contador #(
  parameter int unsigned MODULO        = 10,
  parameter int unsigned LARGURA_CONT  = 4,
  parameter int unsigned LARGURA_DADOS = 8
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     zera_i,
  input  logic                     conta_i,
  input  logic                     registra_i,
  input  logic [LARGURA_DADOS-1:0] dados_i,
  output logic                     fim_contador_o,
  output logic [LARGURA_CONT-1:0]  contagem_o,
  output logic [LARGURA_DADOS-1:0] dado_registrado_o,
  output logic [7:0]               num_registros_o,
  output logic                     pronto_o,
  output logic                     erro_o
);

  localparam logic [LARGURA_CONT-1:0] ContMax = LARGURA_CONT'(MODULO - 1);

  logic [LARGURA_CONT-1:0]  contagem_q, contagem_d;
  logic [LARGURA_DADOS-1:0] dado_q, dado_d;
  logic [7:0]               num_q, num_d;
  logic                     pronto_q, pronto_d;
  logic                     erro_q, erro_d;
  logic                     armado_q, armado_d;

  logic no_fim;
  logic completa;
  logic aceita;

  assign no_fim   = (contagem_q == ContMax);
  // Wrap of a full count arms the next capture.
  assign completa = conta_i & ~zera_i & no_fim;
  // Captures are judged on the pre-edge armado value.
  assign aceita   = registra_i & armado_q;

  always_comb begin
    contagem_d = contagem_q;
    if (zera_i) begin
      contagem_d = '0;
    end else if (conta_i) begin
      contagem_d = no_fim ? '0 : contagem_q + 1'b1;
    end
  end

  always_comb begin
    armado_d = armado_q;
    pronto_d = pronto_q;
    dado_d   = dado_q;
    num_d    = num_q;
    erro_d   = erro_q;

    if (aceita) begin
      armado_d = 1'b0;
      pronto_d = 1'b1;
      dado_d   = dados_i;
      if (num_q != 8'hFF) begin
        num_d = num_q + 8'd1;
      end
    end else if (registra_i) begin
      erro_d = 1'b1;
    end

    // A wrap in the same cycle as an accepted capture re-arms.
    if (completa) begin
      armado_d = 1'b1;
    end

    // zera overrides the capture on armado/pronto only.
    if (zera_i) begin
      armado_d = 1'b0;
      pronto_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      contagem_q <= '0;
      dado_q     <= '0;
      num_q      <= '0;
      pronto_q   <= 1'b0;
      erro_q     <= 1'b0;
      armado_q   <= 1'b0;
    end else begin
      contagem_q <= contagem_d;
      dado_q     <= dado_d;
      num_q      <= num_d;
      pronto_q   <= pronto_d;
      erro_q     <= erro_d;
      armado_q   <= armado_d;
    end
  end

  assign fim_contador_o    = no_fim;
  assign contagem_o        = contagem_q;
  assign dado_registrado_o = dado_q;
  assign num_registros_o   = num_q;
  assign pronto_o          = pronto_q;
  assign erro_o            = erro_q;

endmodule
